// File: rtl/exa_crosb_pkg.sv
// Shared types, sizing constants and the class index helper for the output arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exa_crosb_pkg;

    localparam int INPUT_NUM  = 4;
    localparam int PRIO_NUM   = 2;
    localparam int VC_NUM     = 3;
    localparam int CREDIT_MAX = 8;
    localparam int CLASS_NUM  = PRIO_NUM * VC_NUM;
    localparam int CRED_W     = $clog2(CREDIT_MAX + 1);
    localparam int IN_W       = $clog2(INPUT_NUM);
    localparam int CLS_W      = $clog2(CLASS_NUM);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // A traffic class is one (priority, VC) pair, flattened priority-major.
    function automatic int class_idx(input int p, input int v, input int n_vc = VC_NUM);
        return p * n_vc + v;
    endfunction

endpackage

// File: rtl/exa_crosb_output_arbiter_credit_vc_if.sv
// Request/flit/credit bundle between the input requesters, the arbiter and the output link.
// Latency: n/a (wiring only).
// Backpressure: o_cts gates flits; credits flow back on i_credit_return.
interface exa_crosb_output_arbiter_credit_vc_if
    import exa_crosb_pkg::*;
#(
    parameter int input_num  = INPUT_NUM,
    parameter int prio_num   = PRIO_NUM,
    parameter int vc_num     = VC_NUM,
    parameter int credit_max = CREDIT_MAX
);
    localparam int C   = prio_num * vc_num;
    localparam int CW  = $clog2(credit_max + 1);
    localparam int IW  = $clog2(input_num);
    localparam int CSW = $clog2(C);

    logic [input_num-1:0][C-1:0] i_request;
    logic                        i_valid;
    logic                        i_last;
    logic [C-1:0]                i_credit_return;
    logic [input_num-1:0]        o_grant;
    logic [IW-1:0]               o_input_sel;
    logic [CSW-1:0]              o_class_sel;
    logic                        o_cts;
    logic [C-1:0][CW-1:0]        o_credit_cnt;
    logic                        o_credit_err;

    // Arbiter side.
    modport slave (
        input  i_request, i_valid, i_last, i_credit_return,
        output o_grant, o_input_sel, o_class_sel, o_cts, o_credit_cnt, o_credit_err
    );

    // Requester / link side.
    modport master (
        output i_request, i_valid, i_last, i_credit_return,
        input  o_grant, o_input_sel, o_class_sel, o_cts, o_credit_cnt, o_credit_err
    );

endinterface

// File: rtl/exa_crosb_rr_picker.sv
// Round-robin picker: one-hot grant of the first request after ptr, wrapping around.
// Latency: combinational.
// Backpressure: none; vld is low when no request is present.
module exa_crosb_rr_picker #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          vld
);

    logic [PW-1:0] idx;

    // Scan from ptr+1 upward with wrap; the first hit wins.
    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exa_crosb_output_arbiter_credit_vc.sv
// Per-output crossbar arbiter: strict priority across levels, round-robin inside a level, packet-held grant, per-class credits.
// Latency: request seen in IDLE at n -> grant/cts at n+1; one idle bubble after each last flit.
// Backpressure: o_cts drops while the granted class has no credit; the grant is held until credit returns.
module exa_crosb_output_arbiter_credit_vc
    import exa_crosb_pkg::*;
#(
    parameter int input_num  = INPUT_NUM,
    parameter int prio_num   = PRIO_NUM,
    parameter int vc_num     = VC_NUM,
    parameter int credit_max = CREDIT_MAX
) (
    input  logic clk,
    input  logic reset,
    exa_crosb_output_arbiter_credit_vc_if.slave bus
);

    localparam int C   = prio_num * vc_num;
    localparam int CW  = $clog2(credit_max + 1);
    localparam int IW  = $clog2(input_num);
    localparam int CSW = $clog2(C);
    localparam int PW  = (prio_num > 1) ? $clog2(prio_num) : 1;

    state_e                          state_q, state_d;
    logic [input_num-1:0]            grant_q, grant_d;
    logic [IW-1:0]                   input_sel_q, input_sel_d;
    logic [CSW-1:0]                  class_sel_q, class_sel_d;
    logic [PW-1:0]                   prio_sel_q, prio_sel_d;
    logic [prio_num-1:0][IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [C-1:0][CW-1:0]            credit_q, credit_d;
    logic                            credit_err_q, credit_err_d;

    logic [input_num-1:0][C-1:0]     elig;
    logic [prio_num-1:0][input_num-1:0] prio_req;
    logic [prio_num-1:0][input_num-1:0] prio_gnt;
    logic [prio_num-1:0]             prio_vld;

    logic                            any_vld;
    logic [PW-1:0]                   win_prio;
    logic [input_num-1:0]            win_gnt;
    logic [IW-1:0]                   win_in;
    logic [CSW-1:0]                  win_cls;

    logic                            cts;
    logic                            fire;

    // A pair is eligible only if its class still has downstream space; fold VCs per priority level.
    always_comb begin
        elig     = '0;
        prio_req = '0;
        for (int i = 0; i < input_num; i++) begin
            for (int c = 0; c < C; c++) begin
                elig[i][c] = bus.i_request[i][c] && (credit_q[c] != '0);
            end
        end
        for (int p = 0; p < prio_num; p++) begin
            for (int i = 0; i < input_num; i++) begin
                for (int v = 0; v < vc_num; v++) begin
                    prio_req[p][i] = prio_req[p][i] | elig[i][class_idx(p, v, vc_num)];
                end
            end
        end
    end

    for (genvar gp = 0; gp < prio_num; gp++) begin : g_pick
        exa_crosb_rr_picker #(.N(input_num)) u_pick (
            .req (prio_req[gp]),
            .ptr (rr_ptr_q[gp]),
            .gnt (prio_gnt[gp]),
            .vld (prio_vld[gp])
        );
    end

    // Highest active priority wins; within the chosen input the lowest eligible VC wins.
    always_comb begin
        any_vld  = 1'b0;
        win_prio = '0;
        win_gnt  = '0;
        win_in   = '0;
        win_cls  = '0;
        for (int p = 0; p < prio_num; p++) begin
            if (prio_vld[p]) begin
                any_vld  = 1'b1;
                win_prio = PW'(p);
                win_gnt  = prio_gnt[p];
            end
        end
        for (int i = 0; i < input_num; i++) begin
            if (win_gnt[i]) begin
                win_in = IW'(i);
            end
        end
        for (int v = vc_num - 1; v >= 0; v--) begin
            if (elig[win_in][class_idx(int'(win_prio), v, vc_num)]) begin
                win_cls = CSW'(class_idx(int'(win_prio), v, vc_num));
            end
        end
    end

    // Clear-to-send depends only on registered state and the granted class's counter.
    assign cts  = (state_q == BUSY) && (credit_q[class_sel_q] != '0);
    assign fire = cts && bus.i_valid;

    // IDLE latches a new winner; BUSY holds the grant until the last flit actually moves.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        input_sel_d = input_sel_q;
        class_sel_d = class_sel_q;
        prio_sel_d  = prio_sel_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    grant_d     = win_gnt;
                    input_sel_d = win_in;
                    class_sel_d = win_cls;
                    prio_sel_d  = win_prio;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (fire && bus.i_last) begin
                    rr_ptr_d[prio_sel_q] = input_sel_q;
                    grant_d              = '0;
                    state_d              = IDLE;
                end
            end
        endcase
    end

    // Per-class counter: a consume and a return in the same cycle cancel; a return into a full counter is dropped and flagged.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        for (int c = 0; c < C; c++) begin
            if (fire && (class_sel_q == CSW'(c)) && !bus.i_credit_return[c]) begin
                credit_d[c] = credit_q[c] - CW'(1);
            end else if (!(fire && (class_sel_q == CSW'(c))) && bus.i_credit_return[c]) begin
                if (credit_q[c] == CW'(credit_max)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[c] = credit_q[c] + CW'(1);
                end
            end
        end
    end

    // State registers; reset abandons any packet in flight and refills every class.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            input_sel_q  <= '0;
            class_sel_q  <= '0;
            prio_sel_q   <= '0;
            rr_ptr_q     <= {prio_num{IW'(input_num - 1)}};
            credit_q     <= {C{CW'(credit_max)}};
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            input_sel_q  <= input_sel_d;
            class_sel_q  <= class_sel_d;
            prio_sel_q   <= prio_sel_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign bus.o_grant      = grant_q;
    assign bus.o_input_sel  = input_sel_q;
    assign bus.o_class_sel  = class_sel_q;
    assign bus.o_cts        = cts;
    assign bus.o_credit_cnt = credit_q;
    assign bus.o_credit_err = credit_err_q;

endmodule

// File: doc/exa_crosb_output_arbiter_credit_vc.md
# exa_crosb_output_arbiter_credit_vc

Per-output arbiter for the crossbar with credit-based flow control per traffic class. A class is one (priority, VC) pair. The arbiter selects one input packet at a time and holds the grant until the last flit. Classes are served by strict priority, with round-robin across inputs inside each priority level. Flits pass only while the downstream buffer of the granted class has credit. It sits between the input-side requesters and the output link, one instance per crossbar output.

## Interface
Parameters:
- input_num, 4, number of crossbar inputs
- prio_num, 2, number of priority levels; higher index means higher priority
- vc_num, 3, VCs per priority level
- credit_max, 8, downstream buffer depth per class in flits; also the credit reset value

Ports (C = vc_num*prio_num, class index c = p*vc_num + v, CW = $clog2(credit_max+1)):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_request  in  input_num x C  bit [i][c]: input i holds a packet head of class c
- i_valid  in  1  flit from the selected input is transferred this cycle
- i_last  in  1  qualifies i_valid; marks the last flit of the packet
- i_credit_return  in  C  one credit returned for class c this cycle
- o_grant  out  input_num  one-hot granted input
- o_input_sel  out  $clog2(input_num)  binary index of the granted input
- o_class_sel  out  $clog2(C)  class of the granted packet
- o_cts  out  1  clear-to-send for the next flit
- o_credit_cnt  out  C x CW  current credit count per class
- o_credit_err  out  1  sticky flag: credit overflow

## Operation
- Eligibility: input i is eligible for class c when i_request[i][c]=1 and credit[c]>0.
- FSM has two states, IDLE and BUSY.
- In IDLE:
  - Choose the highest priority p that has any eligible (i,c).
  - Within p, the round-robin picker selects an input, starting from rr_ptr[p]+1 with wrap-around.
  - For the chosen input, pick the lowest eligible v.
  - Register o_grant, o_input_sel and o_class_sel, then go to BUSY.
  - With no eligible pair, stay in IDLE.
- In BUSY:
  - o_cts = (credit[o_class_sel] != 0).
  - A flit moves when i_valid=1 and o_cts=1; it consumes one credit.
  - If i_valid=1 and o_cts=1 and i_last=1:
    - set rr_ptr[p] to the granted input;
    - clear o_grant;
    - return to IDLE.
  - i_valid while o_cts=0 is a protocol violation: it is ignored and consumes no credit.
- Credit update per class: next = cnt - consume + return.
  - Simultaneous consume and return leave the count unchanged.
  - A return when cnt=credit_max (with no consume) is dropped and sets o_credit_err.
- Credits reaching 0 mid-packet stall the packet (o_cts=0) but keep the grant. The packet resumes the cycle after a credit returns.
- Requests changing while BUSY have no effect until the next IDLE.

## Timing
- Reset values:
  - state IDLE
  - o_grant=0, o_input_sel=0, o_class_sel=0, o_cts=0
  - all credit counters = credit_max
  - o_credit_err=0
  - rr_ptr[p] = input_num-1, so input 0 wins first
- Grant latency: a request seen in IDLE at cycle n gives o_grant and o_cts valid at n+1.
- Last flit at cycle n: BUSY is left at n+1 and o_cts=0. The next grant is at n+2, so there is one idle bubble between packets.
- o_cts is combinational from the registered state and the credit counter of the registered class.
- Reset asserted mid-packet:
  - abandons the grant;
  - reloads all counters;
  - returns to IDLE at the next edge.

## Structure
- Package exa_crosb_pkg holds:
  - the state enum typedef {IDLE, BUSY};
  - a class-index function class_idx(p,v) = p*vc_num+v;
  - the width localparams.
- Sub-module exa_crosb_rr_picker: parameter N; inputs a request vector and a pointer; outputs a one-hot grant plus a valid. It is instantiated once per priority level.

## Test plan
- Reset, then input 0 requests class 0 and input 2 requests class 4 (prio 1) → o_grant=4'b0100, o_class_sel=4, o_cts=1 one cycle later.
- All four inputs request class 1; send three 3-flit packets → grants go to inputs 0, 1, 2 in order, each separated by one cycle with o_cts=0.
- credit_max=8, single 10-flit packet, no returns → o_cts drops after flit 8 and o_grant is held. Return 2 credits → o_cts=1 on the following cycle and the packet completes. Counter ends at 0.
- Consume and return on the same class in the same cycle → o_credit_cnt unchanged. A return at count 8 → o_credit_err=1 and stays set until reset.
- Only class-2 requests while credit[2]=0 → stays in IDLE with o_grant=0. After one return, the grant follows two cycles later.
- Assert reset mid-packet → next cycle: o_grant=0, o_cts=0, all counters=8.
